// File: rtl/bp_cfg_stream_rx.sv
// Deserializes and validates a framed processor-config stream, committing it atomically.
// Latency: commit/err visible one cycle after the checksum word; ready_o drops only in RESP.
module bp_cfg_stream_rx #(
  parameter int word_width_p  = 16,
  parameter int num_fields_p  = 16,
  parameter int lg_max_cfgs_p = 7
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [word_width_p-1:0]                data_i,
  input  logic                                   v_i,
  output logic                                   ready_o,
  output logic [num_fields_p*word_width_p-1:0]   cfg_o,
  output logic [lg_max_cfgs_p-1:0]               cfg_id_o,
  output logic                                   cfg_v_o,
  output logic                                   commit_o,
  output logic                                   err_o,
  output logic [1:0]                             err_code_o
);

  localparam int              CW         = (num_fields_p > 1) ? $clog2(num_fields_p) : 1;
  localparam logic [CW-1:0]   LAST_FIELD = CW'(num_fields_p - 1);
  localparam logic [7:0]      MAGIC      = 8'hC5;
  localparam logic [1:0]      CODE_OK    = 2'd0;
  localparam logic [1:0]      CODE_MAGIC = 2'd1;
  localparam logic [1:0]      CODE_ZERO  = 2'd2;
  localparam logic [1:0]      CODE_SUM   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FIELDS,
    S_CHECK,
    S_RESP
  } state_t;

  state_t                              r_state;
  state_t                              w_state_nxt;
  logic [CW-1:0]                       r_cnt;
  logic [word_width_p-1:0]             r_sum;
  logic                                r_zero;
  logic [word_width_p-1:0]             r_shadow [num_fields_p];
  logic [lg_max_cfgs_p-1:0]            r_shadow_id;
  logic [num_fields_p*word_width_p-1:0] r_cfg;
  logic [lg_max_cfgs_p-1:0]            r_cfg_id;
  logic                                r_cfg_v;
  logic                                r_commit;
  logic                                r_err;
  logic [1:0]                          r_err_code;

  logic                                w_acc;
  logic [word_width_p-1:0]             w_sum_nxt;
  logic [lg_max_cfgs_p-1:0]            w_hdr_id;
  logic [1:0]                          w_hdr_code;
  logic [1:0]                          w_resp_code;
  logic [num_fields_p*word_width_p-1:0] w_shadow_flat;

  // ready_o is purely a decode of the state register, never of v_i.
  assign ready_o   = (r_state != S_RESP);
  assign w_acc     = v_i & ready_o;
  assign w_sum_nxt = r_sum + data_i;
  assign w_hdr_id  = data_i[lg_max_cfgs_p-1:0];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_code  = CODE_OK;
    w_resp_code = CODE_OK;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          if ((data_i[word_width_p-1 -: 8] != MAGIC) || data_i[7]) begin
            w_hdr_code = CODE_MAGIC;
          end else if (w_hdr_id == '0) begin
            w_hdr_code = CODE_ZERO;
          end else begin
            w_state_nxt = S_FIELDS;
          end
        end
      end
      S_FIELDS: begin
        if (w_acc && (r_cnt == LAST_FIELD)) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_acc) begin
          w_state_nxt = S_RESP;
          // A bad checksum outranks a zero field.
          if (w_sum_nxt != '0) begin
            w_resp_code = CODE_SUM;
          end else if (r_zero) begin
            w_resp_code = CODE_ZERO;
          end
        end
      end
      S_RESP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    w_shadow_flat = '0;
    for (int k = 0; k < num_fields_p; k++) begin
      w_shadow_flat[k*word_width_p +: word_width_p] = r_shadow[k];
    end
  end

  // Pulses are set on the accepting edge so they land in the cycle after it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_cnt       <= '0;
      r_sum       <= '0;
      r_zero      <= 1'b0;
      r_shadow_id <= '0;
      r_cfg       <= '0;
      r_cfg_id    <= '0;
      r_cfg_v     <= 1'b0;
      r_commit    <= 1'b0;
      r_err       <= 1'b0;
      r_err_code  <= CODE_OK;
      for (int k = 0; k < num_fields_p; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_commit   <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= CODE_OK;
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_hdr_code != CODE_OK) begin
              r_err      <= 1'b1;
              r_err_code <= w_hdr_code;
            end else begin
              r_shadow_id <= w_hdr_id;
              r_sum       <= data_i;
              r_cnt       <= '0;
              r_zero      <= 1'b0;
            end
          end
        end
        S_FIELDS: begin
          if (w_acc) begin
            r_shadow[r_cnt] <= data_i;
            r_sum           <= w_sum_nxt;
            if (data_i == '0) begin
              r_zero <= 1'b1;
            end
            if (r_cnt != LAST_FIELD) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (w_acc) begin
            r_sum <= w_sum_nxt;
            if (w_resp_code == CODE_OK) begin
              r_cfg    <= w_shadow_flat;
              r_cfg_id <= r_shadow_id;
              r_cfg_v  <= 1'b1;
              r_commit <= 1'b1;
            end else begin
              r_err      <= 1'b1;
              r_err_code <= w_resp_code;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign cfg_o      = r_cfg;
  assign cfg_id_o   = r_cfg_id;
  assign cfg_v_o    = r_cfg_v;
  assign commit_o   = r_commit;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

endmodule

// File: tb/tb_bp_cfg_stream_rx.sv
// Scoreboard bench for bp_cfg_stream_rx: expected commit/err events are queued as frames are
// driven and checked against the DUT's pulses by a monitor forked from the main initial block.
module tb_bp_cfg_stream_rx;

  typedef logic [15:0] fld_t [16];
  typedef struct {
    bit           commit;
    logic [1:0]   code;
    logic [6:0]   id;
    logic [255:0] cfg;
    logic         v;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [15:0]  data_i;
  logic         v_i;
  logic         ready_o;
  logic [255:0] cfg_o;
  logic [6:0]   cfg_id_o;
  logic         cfg_v_o;
  logic         commit_o;
  logic         err_o;
  logic [1:0]   err_code_o;

  int           n_assert = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           commits = 0;
  int           last_commit_cyc = -1;
  int           ready_low_cnt = 0;
  exp_t         sb [$];
  logic [255:0] m_cfg;
  logic [6:0]   m_id;
  logic         m_v;
  fld_t         f_single;
  fld_t         f_dual;

  bp_cfg_stream_rx #(
    .word_width_p (16),
    .num_fields_p (16),
    .lg_max_cfgs_p(7)
  ) dut (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (data_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .cfg_o     (cfg_o),
    .cfg_id_o  (cfg_id_o),
    .cfg_v_o   (cfg_v_o),
    .commit_o  (commit_o),
    .err_o     (err_o),
    .err_code_o(err_code_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [15:0] chk_of(input logic [15:0] hdr, input fld_t f);
    logic [15:0] s;
    s = hdr;
    for (int k = 0; k < 16; k++) s = s + f[k];
    return 16'(16'h0000 - s);
  endfunction

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!ready_o) ready_low_cnt++;
      if (commit_o || err_o) begin
        if (commit_o) begin
          commits++;
          last_commit_cyc = cyc;
        end
        n_assert++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: commit=%0b err=%0b code=%0d, required no event", commit_o, err_o, err_code_o);
        end else begin
          e = sb.pop_front();
          n_assert++;
          if ({commit_o, err_o, err_code_o} !== {e.commit, !e.commit, e.code}) begin
            n_fail++;
            $display("FAIL sb_kind: commit=%0b err=%0b code=%0d, required commit=%0b code=%0d", commit_o, err_o, err_code_o, e.commit, e.code);
          end
          n_assert++;
          if ({cfg_v_o, cfg_id_o, cfg_o} !== {e.v, e.id, e.cfg}) begin
            n_fail++;
            $display("FAIL sb_cfg: v=%0b id=%0d cfg=%h, required v=%0b id=%0d cfg=%h", cfg_v_o, cfg_id_o, cfg_o, e.v, e.id, e.cfg);
          end
        end
      end else begin
        n_assert++;
        if (err_code_o !== 2'd0) begin
          n_fail++;
          $display("FAIL err_code_idle: got %0d, required 0", err_code_o);
        end
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 3)) begin
        v_i = 1'b0;
        @(posedge clk_i);
        #1;
      end
    end
    v_i    = 1'b1;
    data_i = w;
    n      = 0;
    while (ready_o !== 1'b1) begin
      @(posedge clk_i);
      #1;
      n++;
      if (n > 100) begin
        $display("FAIL ready_timeout: ready_o=%b after %0d cycles, required 1", ready_o, n);
        $fatal(1, "ready_o stuck low");
      end
    end
    @(posedge clk_i);
    #1;
    v_i = 1'b0;
  endtask

  task automatic push_hdr_err(input logic [1:0] code);
    exp_t e;
    e.commit = 1'b0; e.code = code; e.id = m_id; e.cfg = m_cfg; e.v = m_v;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [15:0] hdr, input fld_t f, input logic [15:0] chk, input bit gaps);
    exp_t        e;
    logic [15:0] s;
    bit          z;
    s = hdr + chk;
    z = 1'b0;
    send_word(hdr, gaps);
    for (int k = 0; k < 16; k++) begin
      send_word(f[k], gaps);
      s = s + f[k];
      if (f[k] == 16'd0) z = 1'b1;
    end
    send_word(chk, gaps);
    e.code = (s != 16'd0) ? 2'd3 : (z ? 2'd2 : 2'd0);
    e.commit = (e.code == 2'd0);
    if (e.commit) begin
      for (int k = 0; k < 16; k++) m_cfg[k*16 +: 16] = f[k];
      m_id = hdr[6:0];
      m_v  = 1'b1;
    end
    e.id = m_id; e.cfg = m_cfg; e.v = m_v;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d events pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    v_i       = 1'b0;
    data_i    = 16'd0;
    m_cfg = '0; m_id = '0; m_v = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b, required 1", ready_o); end
    n_assert++;
    if (cfg_o !== '0) begin n_fail++; $display("FAIL rst_cfg: got %h, required 0", cfg_o); end
    n_assert++;
    if (cfg_id_o !== 7'd0) begin n_fail++; $display("FAIL rst_cfg_id: got %0d, required 0", cfg_id_o); end
    n_assert++;
    if (cfg_v_o !== 1'b0) begin n_fail++; $display("FAIL rst_cfg_v: got %b, required 0", cfg_v_o); end
    n_assert++;
    if ({commit_o, err_o, err_code_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_pulses: commit=%b err=%b code=%0d, required 0", commit_o, err_o, err_code_o);
    end
  endtask

  task automatic test_single_frame();
    int hdr_cyc;
    ready_low_cnt = 0;
    hdr_cyc = cyc;
    send_frame(16'hC501, f_single, 16'h37EE, 1'b0);
    drain();
    repeat (3) @(posedge clk_i);
    #1;
    // Header cycle counts as cycle 1; commit lands in cycle 19.
    n_assert++;
    if (last_commit_cyc - hdr_cyc !== 18) begin
      n_fail++;
      $display("FAIL single_latency: commit %0d cycles after header cycle, required 18", last_commit_cyc - hdr_cyc);
    end
    n_assert++;
    if (cfg_id_o !== 7'd1) begin n_fail++; $display("FAIL single_id: got %0d, required 1", cfg_id_o); end
    n_assert++;
    if (cfg_o[12*16 +: 16] !== 16'd512) begin n_fail++; $display("FAIL single_f12: got %0d, required 512", cfg_o[12*16 +: 16]); end
    n_assert++;
    if (cfg_v_o !== 1'b1) begin n_fail++; $display("FAIL single_v: got %b, required 1", cfg_v_o); end
    n_assert++;
    if (ready_low_cnt !== 1) begin n_fail++; $display("FAIL single_ready_low: got %0d cycles, required 1", ready_low_cnt); end
  endtask

  task automatic test_bad_checksum();
    send_frame(16'hC501, f_single, 16'h37EF, 1'b0);
    drain();
  endtask

  task automatic test_header_errors();
    int c0;
    c0 = commits;
    send_word(16'hA501, 1'b0);
    push_hdr_err(2'd1);
    send_word(16'hC500, 1'b0);
    push_hdr_err(2'd2);
    send_word(16'hC581, 1'b0);
    push_hdr_err(2'd1);
    drain();
    n_assert++;
    if (ready_o !== 1'b1 || commits !== c0) begin
      n_fail++;
      $display("FAIL hdr_idle: ready=%b commits=+%0d, required ready=1 commits=+0", ready_o, commits - c0);
    end
  endtask

  task automatic test_zero_field();
    fld_t f;
    f    = f_single;
    f[5] = 16'd0;
    send_frame(16'hC503, f, chk_of(16'hC503, f), 1'b0);
    drain();
  endtask

  task automatic test_back_to_back_gaps();
    int c0;
    c0 = commits;
    send_frame(16'hC501, f_single, 16'h37EE, 1'b1);
    send_frame(16'hC502, f_dual, chk_of(16'hC502, f_dual), 1'b1);
    drain();
    n_assert++;
    if (cfg_id_o !== 7'd2) begin n_fail++; $display("FAIL dual_id: got %0d, required 2", cfg_id_o); end
    n_assert++;
    if (cfg_o[15:0] !== 16'd2 || cfg_o[47:32] !== 16'd4) begin
      n_fail++;
      $display("FAIL dual_fields: f0=%0d f2=%0d, required f0=2 f2=4", cfg_o[15:0], cfg_o[47:32]);
    end
    n_assert++;
    if (commits - c0 !== 2) begin n_fail++; $display("FAIL dual_commits: got %0d, required 2", commits - c0); end
  endtask

  task automatic test_reset_mid_frame();
    send_word(16'hC504, 1'b0);
    for (int k = 0; k < 5; k++) send_word(f_dual[k], 1'b0);
    reset_n_i = 1'b0;
    #1;
    m_cfg = '0; m_id = '0; m_v = 1'b0;
    n_assert++;
    if ({cfg_o, cfg_id_o, cfg_v_o, commit_o, err_o, err_code_o} !== '0 || ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_outputs: cfg=%h id=%0d v=%b commit=%b err=%b ready=%b, required zeros and ready=1",
               cfg_o, cfg_id_o, cfg_v_o, commit_o, err_o, ready_o);
    end
    @(posedge clk_i);
    #1;
    reset_n_i = 1'b1;
    send_frame(16'hC505, f_single, chk_of(16'hC505, f_single), 1'b0);
    drain();
    n_assert++;
    if (cfg_id_o !== 7'd5 || cfg_v_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_recommit: id=%0d v=%b, required id=5 v=1", cfg_id_o, cfg_v_o);
    end
  endtask

  initial begin
    f_single = '{16'd1, 16'd1, 16'd2, 16'd39, 16'd56, 16'd1, 16'd10, 16'd6,
                 16'd9, 16'd2, 16'd64, 16'd8, 16'd512, 16'd8, 16'd2, 16'd64};
    f_dual   = '{16'd2, 16'd2, 16'd4, 16'd39, 16'd56, 16'd1, 16'd10, 16'd6,
                 16'd9, 16'd2, 16'd64, 16'd8, 16'd512, 16'd8, 16'd2, 16'd64};
    test_reset();
    fork
      monitor();
    join_none
    test_single_frame();
    test_bad_checksum();
    test_header_errors();
    test_zero_field();
    test_back_to_back_gaps();
    test_reset_mid_frame();
    repeat (5) @(posedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
